uart_mem_loader: RTL
====================

Name: uart_mem_loader

Overview:
Framed UART-to-memory loader and the successor to the byte-packing instruction-memory interface.
- Consumes bytes from the UART receiver (rx_done_tick style pulses) and parses a framed load command.
- Packs bytes into NB_DATA-bit words and streams them into an instruction/data memory write port.
- Verifies an XOR checksum and returns an ACK/NAK byte through the UART transmitter handshake.
- Generalised in word width, memory depth and byte order.

Parameters:
NB_DATA, 32, memory word width; must be a multiple of NB_BYTE.
NB_BYTE, 8, UART byte width.
ADDR_WIDTH, 7, memory address width; DEPTH = 2**ADDR_WIDTH words.
MSB_FIRST, 1, 1: first byte of a word lands in the MSBs; 0: first byte lands in the LSBs.
SYNC_BYTE, 8'hA5, frame start marker.
ACK_BYTE, 8'h06, response for a good frame.
NAK_BYTE, 8'h15, response for a bad frame.
TIMEOUT_CYCLES, 3000000, inter-byte timeout in clocks; used only with LOADER_TIMEOUT_EN.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
rx_valid  in  1  one-cycle pulse, rx_data valid.
rx_data  in  NB_BYTE  received byte.
tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
tx_data  out  NB_BYTE  response byte; held stable until tx_done.
tx_done  in  1  one-cycle pulse, transmitter finished.
mem_wr_en  out  1  one-cycle write strobe.
mem_addr  out  ADDR_WIDTH  write word address.
mem_data  out  NB_DATA  write word.
busy  out  1  frame in progress (any state except IDLE).
load_done  out  1  level; last frame was good.
load_error  out  1  level; last frame was bad.
words_loaded  out  ADDR_WIDTH+1  words written in the current/last frame.

Behaviour:
- Reset (asynchronous, active-high): state IDLE. All outputs 0, including tx_data, mem_addr and mem_data. Byte counter, word counter and checksum cleared.
- Frame format: SYNC_BYTE, COUNT (1 byte, number of words N), N*BPW data bytes, CSUM. BPW = NB_DATA/NB_BYTE. CSUM = XOR of all data bytes.
- State machine:
  - IDLE: rx_valid with SYNC_BYTE -> COUNT; clears load_done, load_error, words_loaded and the checksum. Any other byte is ignored.
  - COUNT: rx_valid -> latch N.
    - N==0 or N>DEPTH -> RESP with NAK.
    - Otherwise -> DATA.
  - DATA: each rx_valid shifts the byte into the word register per MSB_FIRST and XORs it into the checksum.
    - On the BPW-th byte: mem_wr_en=1 in the following cycle, with mem_addr = word index and mem_data = the packed word. Then the address increments and words_loaded increments.
    - After the N-th word -> CSUM.
  - CSUM: rx_valid -> compare with the accumulated checksum. Match -> RESP with ACK; mismatch -> RESP with NAK.
  - RESP: tx_data = chosen byte, tx_start pulsed for exactly one cycle -> WAIT_TX.
  - WAIT_TX: on tx_done -> IDLE. load_done=1 if ACK, else load_error=1; these flags are set in the same cycle as the return to IDLE.
- Latency:
  - Write strobe is 1 cycle after the rx_valid that completes a word.
  - tx_start is 1 cycle after entering RESP, i.e. 2 cycles after the CSUM byte.
- rx_valid in RESP/WAIT_TX is dropped and has no side effects.
- tx_done outside WAIT_TX is ignored.
- Words written before a NAK remain in memory. Consumers must gate on load_done.
- Data bytes equal to SYNC_BYTE inside DATA/CSUM are treated as data, not as a resync.
- mem_addr wraps never; the N>DEPTH rejection guarantees this.
- Reset mid-frame aborts immediately; no partial write strobe is issued after reset.

Optional Feature:
LOADER_TIMEOUT_EN:
- Defined: a counter reloads on every rx_valid in COUNT/DATA/CSUM and counts down while in those states. On reaching 0 -> RESP with NAK, and the partial word is discarded.
- Undefined: no counter; the FSM waits indefinitely for bytes.

Decomposition:
- Shared package: state encoding, default SYNC_BYTE/ACK_BYTE/NAK_BYTE constants, BPW derivation.
- One natural sub-module: loader_word_packer. It contains the byte shift register, the byte-in-word counter, MSB_FIRST ordering and the word_ready pulse.
- FSM, checksum and response logic stay in the top.

Test Plan:
1. Good frame: A5 02 11 22 33 44 55 66 77 88 88.
   - Writes: addr0=0x11223344, addr1=0x55667788.
   - Response: tx_data=0x06, then load_done=1 and words_loaded=2.
2. Same frame with CSUM 0x89 -> both words written, tx_data=0x15, load_error=1, load_done=0.
3. A5 00, and separately A5 81 (129 > DEPTH 128) -> no mem_wr_en, NAK 0x15 immediately after the COUNT byte.
4. MSB_FIRST=0, frame A5 01 11 22 33 44 44 -> addr0=0x44332211, ACK.
5. Reset asserted after 3 data bytes -> busy=0 and all outputs 0 asynchronously. No write strobe follows. A subsequent good frame loads correctly.
6. LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=100, stream stops after A5 01 11 -> NAK 0x15 about 100 cycles later, and load_error=1 after tx_done.

Source files
------------

// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the framed UART memory loader: FSM state encoding,
// default frame marker/response bytes and the bytes-per-word derivation.
package uart_mem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DATA,
      ST_CSUM,
      ST_RESP,
      ST_WAIT_TX
   } state_e;

   localparam int unsigned DEF_NB_DATA    = 32;
   localparam int unsigned DEF_NB_BYTE    = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 7;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
   localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
   localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

   function automatic int unsigned calc_bpw(input int unsigned nb_data, input int unsigned nb_byte);
      return nb_data / nb_byte;
   endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// UART byte handshake and memory write port of the loader, bundled as one interface.
// The master modport is the loader side; the slave modport is the UART/memory side.
interface uart_mem_loader_if
   import uart_mem_loader_pkg::*;
#(
   parameter int unsigned NB_DATA    = DEF_NB_DATA,
   parameter int unsigned NB_BYTE    = DEF_NB_BYTE,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

   logic                  rx_valid;
   logic [NB_BYTE-1:0]    rx_data;
   logic                  tx_start;
   logic [NB_BYTE-1:0]    tx_data;
   logic                  tx_done;
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [NB_DATA-1:0]    mem_data;

   modport master (
      input  rx_valid, rx_data, tx_done,
      output tx_start, tx_data, mem_wr_en, mem_addr, mem_data
   );

   modport slave (
      output rx_valid, rx_data, tx_done,
      input  tx_start, tx_data, mem_wr_en, mem_addr, mem_data
   );

endinterface

// File: rtl/loader_word_packer.sv
// Packs incoming bytes into NB_DATA-bit words in MSB_FIRST or LSB_FIRST order and
// pulses word_ready_o for one cycle right after the byte that completes a word.
module loader_word_packer
   import uart_mem_loader_pkg::*;
#(
   parameter int unsigned NB_DATA   = DEF_NB_DATA,
   parameter int unsigned NB_BYTE   = DEF_NB_BYTE,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear_i,
   input  logic               byte_valid_i,
   input  logic [NB_BYTE-1:0] byte_i,
   output logic [NB_DATA-1:0] word_o,
   output logic               word_ready_o,
   output logic               word_last_o
);

   localparam int unsigned BPW = calc_bpw(NB_DATA, NB_BYTE);
   localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [CW-1:0]      idx_q;
   logic [NB_DATA-1:0] word_q;
   logic [NB_DATA-1:0] word_d;
   logic               ready_q;

   assign word_last_o  = (idx_q == CW'(BPW - 1));
   assign word_o       = word_q;
   assign word_ready_o = ready_q;

   // Shifting in place means the first byte ends at the far end once the word is full.
   generate
      if (BPW == 1) begin : g_single
         assign word_d = byte_i;
      end else if (MSB_FIRST) begin : g_msb
         assign word_d = {word_q[NB_DATA-NB_BYTE-1:0], byte_i};
      end else begin : g_lsb
         assign word_d = {byte_i, word_q[NB_DATA-1:NB_BYTE]};
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         word_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (clear_i) begin
            idx_q <= '0;
         end else if (byte_valid_i) begin
            word_q  <= word_d;
            ready_q <= word_last_o;
            idx_q   <= word_last_o ? '0 : idx_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_mem_loader.sv
// Framed UART-to-memory loader: SYNC, COUNT, N packed words, XOR checksum, ACK/NAK reply.
// Optional inter-byte timeout is compiled in with `define LOADER_TIMEOUT_EN.
module uart_mem_loader
   import uart_mem_loader_pkg::*;
#(
   parameter int unsigned         NB_DATA        = DEF_NB_DATA,
   parameter int unsigned         NB_BYTE        = DEF_NB_BYTE,
   parameter int unsigned         ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter bit                  MSB_FIRST      = 1'b1,
   parameter logic [NB_BYTE-1:0]  SYNC_BYTE      = NB_BYTE'(DEF_SYNC_BYTE),
   parameter logic [NB_BYTE-1:0]  ACK_BYTE       = NB_BYTE'(DEF_ACK_BYTE),
   parameter logic [NB_BYTE-1:0]  NAK_BYTE       = NB_BYTE'(DEF_NAK_BYTE),
   parameter int unsigned         TIMEOUT_CYCLES = 3000000
) (
   input  logic                  clock,
   input  logic                  reset,
   uart_mem_loader_if.master     bus,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   state_e              state_q;
   logic [NB_BYTE-1:0]  pending_q;
   logic [NB_BYTE-1:0]  csum_q;
   logic [NB_BYTE-1:0]  tx_data_q;
   logic                tx_start_q;
   logic                ack_q;
   logic                load_done_q;
   logic                load_error_q;
   logic [ADDR_WIDTH:0] words_q;

   logic               sync_hit;
   logic               active;
   logic               timeout_hit;
   logic               byte_valid;
   logic               pack_clear;
   logic               word_ready;
   logic               word_last;
   logic [NB_DATA-1:0] word;

   assign sync_hit   = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
   assign active     = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign byte_valid = (state_q == ST_DATA) && bus.rx_valid;
   assign pack_clear = ((state_q == ST_IDLE) && sync_hit) || timeout_hit;

   loader_word_packer #(
      .NB_DATA   (NB_DATA),
      .NB_BYTE   (NB_BYTE),
      .MSB_FIRST (MSB_FIRST)
   ) u_packer (
      .clock        (clock),
      .reset        (reset),
      .clear_i      (pack_clear),
      .byte_valid_i (byte_valid),
      .byte_i       (bus.rx_data),
      .word_o       (word),
      .word_ready_o (word_ready),
      .word_last_o  (word_last)
   );

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q;

   assign timeout_hit = active && !bus.rx_valid && (tmo_q == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tmo_q <= '0;
      end else if (((state_q == ST_IDLE) && sync_hit) || (active && bus.rx_valid)) begin
         tmo_q <= TW'(TIMEOUT_CYCLES);
      end else if (active && (tmo_q != '0)) begin
         tmo_q <= tmo_q - TW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // The word address doubles as the loaded-word count; it advances after each strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         csum_q       <= '0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         ack_q        <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         words_q      <= '0;
      end else begin
         tx_start_q <= 1'b0;
         if (word_ready) begin
            words_q <= words_q + (ADDR_WIDTH + 1)'(1);
         end
         unique case (state_q)
            ST_IDLE: begin
               if (sync_hit) begin
                  state_q      <= ST_COUNT;
                  load_done_q  <= 1'b0;
                  load_error_q <= 1'b0;
                  words_q      <= '0;
                  csum_q       <= '0;
               end
            end
            ST_COUNT: begin
               if (bus.rx_valid) begin
                  pending_q <= bus.rx_data;
                  if ((bus.rx_data == '0) || (32'(bus.rx_data) > DEPTH)) begin
                     ack_q     <= 1'b0;
                     tx_data_q <= NAK_BYTE;
                     state_q   <= ST_RESP;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end else if (timeout_hit) begin
                  ack_q     <= 1'b0;
                  tx_data_q <= NAK_BYTE;
                  state_q   <= ST_RESP;
               end
            end
            ST_DATA: begin
               if (bus.rx_valid) begin
                  csum_q <= csum_q ^ bus.rx_data;
                  if (word_last) begin
                     pending_q <= pending_q - NB_BYTE'(1);
                     if (pending_q == NB_BYTE'(1)) begin
                        state_q <= ST_CSUM;
                     end
                  end
               end else if (timeout_hit) begin
                  ack_q     <= 1'b0;
                  tx_data_q <= NAK_BYTE;
                  state_q   <= ST_RESP;
               end
            end
            ST_CSUM: begin
               if (bus.rx_valid) begin
                  ack_q     <= (bus.rx_data == csum_q);
                  tx_data_q <= (bus.rx_data == csum_q) ? ACK_BYTE : NAK_BYTE;
                  state_q   <= ST_RESP;
               end else if (timeout_hit) begin
                  ack_q     <= 1'b0;
                  tx_data_q <= NAK_BYTE;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               tx_start_q <= 1'b1;
               state_q    <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (bus.tx_done) begin
                  load_done_q  <= ack_q;
                  load_error_q <= !ack_q;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.tx_start  = tx_start_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.mem_wr_en = word_ready;
   assign bus.mem_addr  = words_q[ADDR_WIDTH-1:0];
   assign bus.mem_data  = word;

   assign busy         = (state_q != ST_IDLE);
   assign load_done    = load_done_q;
   assign load_error   = load_error_q;
   assign words_loaded = words_q;

endmodule
